ysyx_23060191_lsu_ctrl: RTL and testbench
=========================================

// Module: ysyx_23060191_lsu_ctrl
// PURPOSE
//  Multi-cycle load/store unit between EXU and WBU. Accepts one memory op per handshake
//  (address = EXU result, store data = Rs2), drives a word-aligned req/gnt/rvalid data-memory
//  port, aligns/masks store data, extracts and sign/zero-extends load data, returns it to WBU.
//  Non-memory ops pass through in one cycle, keeping the valid/ready pipeline uniform.
// PARAMETERS
//  CPU_WIDTH      32  data/address width (only 32 supported)
//  LSU_OPT_WIDTH  4   width of lsu_opt_code
// PORTS
//  clk           in   1   clock
//  rstn          in   1   asynchronous active-low reset
//  in_valid      in   1   EXU has an op
//  in_ready      out  1   LSU can accept (high only in IDLE)
//  lsu_opt_code  in   4   0=NONE 1=LB 2=LH 3=LW 4=LBU 5=LHU 9=SB 10=SH 11=SW; others=NONE
//  addr          in   32  effective address (EXU result)
//  data_store    in   32  store data (Rs2)
//  exu_res       in   32  value forwarded as out_data for NONE ops (equal to addr port source)
//  out_valid     out  1   result valid to WBU
//  out_ready     in   1   WBU accepts
//  out_data      out  32  load result, or exu_res for NONE, 0 for stores
//  out_err       out  1   misaligned access flag, qualified by out_valid
//  mem_req       out  1   memory request
//  mem_we        out  1   1=write
//  mem_addr      out  32  {addr[31:2],2'b00}
//  mem_wdata     out  32  data_store shifted left by 8*addr[1:0]
//  mem_wmask     out  4   byte enables (SB 4'b0001<<a, SH 4'b0011<<a, SW 4'b1111)
//  mem_gnt       in   1   request accepted this cycle
//  mem_rvalid    in   1   response (read data or write ack) this cycle
//  mem_rdata     in   32  read word
// BEHAVIOUR
//  Reset (rstn=0, async): state=IDLE; in_ready=1; out_valid=0; out_data=0; out_err=0;
//   mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; mem_wmask=0. All capture regs cleared.
//  FSM IDLE -> REQ -> WAIT -> RESP -> IDLE.
//  IDLE: in_ready=1. On in_valid: latch opcode, addr, data_store, exu_res.
//   NONE -> RESP (out_data=exu_res), latency 1 cycle.
//   Misaligned (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0) -> RESP with out_err=1, out_data=0,
//    no memory access issued.
//   Else -> REQ.
//  REQ: mem_req=1 and mem_addr/we/wdata/wmask held stable until mem_gnt=1; gnt -> WAIT,
//   mem_req drops next cycle. mem_wmask=0 for loads.
//  WAIT: on mem_rvalid -> RESP; loads capture mem_rdata. rvalid in same cycle as gnt is
//   legal: REQ goes straight to RESP (min mem latency 1 cycle after acceptance).
//  RESP: out_valid=1, out_data/out_err stable until out_ready; on out_ready -> IDLE.
//   Back-to-back throughput: new op accepted the cycle after out_ready handshake.
//  Load extraction: byte b=rdata[8*a+:8], half h=rdata[16*a[1]+:16]; LB sext(b), LBU zext(b),
//   LH sext(h), LHU zext(h), LW rdata. Stores: out_data=0.
//  in_ready=0 outside IDLE; in_valid ignored there. Only one outstanding memory op.
//  mem_rvalid in IDLE/REQ/RESP is ignored (protocol error, no state change).
//  Reset mid-operation: returns to IDLE immediately; any in-flight access is abandoned,
//   late rvalid after reset is ignored.
// TESTING
//  SW addr=0x80000004 data=0xDEADBEEF, gnt same cycle, rvalid +1 -> mem_wmask=4'hF,
//   mem_wdata=0xDEADBEEF, out_valid once, out_data=0, out_err=0.
//  SB addr=0x80000003 data=0x000000A5 -> mem_addr=0x80000000, mem_wmask=4'b1000,
//   mem_wdata=0xA5000000.
//  LB/LBU addr=...02, mem_rdata=0x12F45678 -> LB out_data=0xFFFFFFF4, LBU 0x000000F4;
//   LH addr=...02 -> 0x000012F4.
//  LW addr=0x80000002 -> no mem_req, out_valid 1 cycle after accept, out_err=1, out_data=0.
//  Backpressure: mem_gnt low 3 cycles, rvalid +2, out_ready low 4 cycles -> mem_* stable
//   during REQ, out_data stable in RESP, in_ready=0 throughout; NONE op exu_res=0x1234
//   -> out_data=0x1234 latency 1.
//  Assert rstn=0 in WAIT, then rvalid after release -> outputs at reset values, state IDLE,
//   no out_valid.

Source files
------------

// File: rtl/ysyx_23060191_lsu_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ysyx_23060191_lsu_ctrl : multi-cycle load/store unit between EXU and WBU
// Revision 1.0
// ---------------------------------------------------------------------------
module ysyx_23060191_lsu_ctrl #(
  parameter int CPU_WIDTH     = 32,
  parameter int LSU_OPT_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LSU_OPT_WIDTH-1:0] lsu_opt_code,
  input  logic [CPU_WIDTH-1:0]     addr,
  input  logic [CPU_WIDTH-1:0]     data_store,
  input  logic [CPU_WIDTH-1:0]     exu_res,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CPU_WIDTH-1:0]     out_data,
  output logic                     out_err,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [CPU_WIDTH-1:0]     mem_addr,
  output logic [CPU_WIDTH-1:0]     mem_wdata,
  output logic [3:0]               mem_wmask,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [CPU_WIDTH-1:0]     mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [LSU_OPT_WIDTH-1:0] OP_LB  = 4'd1;
  localparam logic [LSU_OPT_WIDTH-1:0] OP_LH  = 4'd2;
  localparam logic [LSU_OPT_WIDTH-1:0] OP_LW  = 4'd3;
  localparam logic [LSU_OPT_WIDTH-1:0] OP_LBU = 4'd4;
  localparam logic [LSU_OPT_WIDTH-1:0] OP_LHU = 4'd5;
  localparam logic [LSU_OPT_WIDTH-1:0] OP_SB  = 4'd9;
  localparam logic [LSU_OPT_WIDTH-1:0] OP_SH  = 4'd10;
  localparam logic [LSU_OPT_WIDTH-1:0] OP_SW  = 4'd11;

  logic [1:0]               state;
  logic [LSU_OPT_WIDTH-1:0] op_q;
  logic [1:0]               lo_q;

  logic                     is_load;
  logic                     is_store;
  logic                     misaligned;
  logic [3:0]               wmask_n;
  logic [CPU_WIDTH-1:0]     wdata_n;
  logic [CPU_WIDTH-1:0]     rshift;
  logic [7:0]               rbyte;
  logic [15:0]              rhalf;
  logic [CPU_WIDTH-1:0]     load_val;

  assign in_ready = (state == S_IDLE);

  // Decode of the op currently presented by EXU.
  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    wmask_n    = 4'b0000;
    case (lsu_opt_code)
      OP_LB, OP_LBU: is_load = 1'b1;
      OP_LH, OP_LHU: begin
        is_load    = 1'b1;
        misaligned = addr[0];
      end
      OP_LW: begin
        is_load    = 1'b1;
        misaligned = |addr[1:0];
      end
      OP_SB: begin
        is_store = 1'b1;
        wmask_n  = 4'b0001 << addr[1:0];
      end
      OP_SH: begin
        is_store   = 1'b1;
        misaligned = addr[0];
        wmask_n    = 4'b0011 << addr[1:0];
      end
      OP_SW: begin
        is_store   = 1'b1;
        misaligned = |addr[1:0];
        wmask_n    = 4'b1111;
      end
      default: ;
    endcase
  end

  assign wdata_n = data_store << {addr[1:0], 3'b000};

  // Load extraction uses the byte offset captured at accept time.
  assign rshift = mem_rdata >> {lo_q, 3'b000};
  assign rbyte  = rshift[7:0];
  assign rhalf  = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_val = '0;
    case (op_q)
      OP_LB:   load_val = {{24{rbyte[7]}}, rbyte};
      OP_LBU:  load_val = {24'd0, rbyte};
      OP_LH:   load_val = {{16{rhalf[15]}}, rhalf};
      OP_LHU:  load_val = {16'd0, rhalf};
      OP_LW:   load_val = mem_rdata;
      default: load_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      op_q      <= '0;
      lo_q      <= 2'b00;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= 4'b0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q <= lsu_opt_code;
            lo_q <= addr[1:0];
            if (!is_load && !is_store) begin
              out_valid <= 1'b1;
              out_data  <= exu_res;
              out_err   <= 1'b0;
              state     <= S_RESP;
            end else if (misaligned) begin
              out_valid <= 1'b1;
              out_data  <= '0;
              out_err   <= 1'b1;
              state     <= S_RESP;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[CPU_WIDTH-1:2], 2'b00};
              mem_wdata <= wdata_n;
              mem_wmask <= wmask_n;
              state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            // A response in the grant cycle completes the access immediately.
            if (mem_rvalid) begin
              out_valid <= 1'b1;
              out_data  <= load_val;
              out_err   <= 1'b0;
              state     <= S_RESP;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            out_valid <= 1'b1;
            out_data  <= load_val;
            out_err   <= 1'b0;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060191_lsu_ctrl.sv
`default_nettype none
// Scoreboard bench for ysyx_23060191_lsu_ctrl: directed cases, then randomized ops.
module tb_ysyx_23060191_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  lsu_opt_code;
  logic [31:0] addr;
  logic [31:0] data_store;
  logic [31:0] exu_res;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  ysyx_23060191_lsu_ctrl #(.CPU_WIDTH(32), .LSU_OPT_WIDTH(4)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .lsu_opt_code(lsu_opt_code), .addr(addr), .data_store(data_store), .exu_res(exu_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        fast;
  } out_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_t;

  out_t        out_q[$];
  mem_t        mem_q[$];
  logic [31:0] rdata_q[$];

  int total  = 0;
  int passed = 0;

  // Responder / backpressure controls
  bit manual_mem = 1'b0;
  bit noise      = 1'b0;
  bit rand_ready = 1'b0;
  int gnt_cfg    = -1;
  int rv_cfg     = -1;
  int stall_left = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  // Reference behaviour computed from the op rules with plain arithmetic.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] exu, input logic [31:0] rd,
                                output out_t o, output bit hm, output mem_t m);
    int size;
    bit ld, st, sgn;
    int off;
    logic [63:0] w, mask;
    size = 1; ld = 0; st = 0; sgn = 0;
    off = int'(a % 4);
    case (op)
      4'd1:  begin ld = 1; size = 1; sgn = 1; end
      4'd2:  begin ld = 1; size = 2; sgn = 1; end
      4'd3:  begin ld = 1; size = 4; end
      4'd4:  begin ld = 1; size = 1; end
      4'd5:  begin ld = 1; size = 2; end
      4'd9:  begin st = 1; size = 1; end
      4'd10: begin st = 1; size = 2; end
      4'd11: begin st = 1; size = 4; end
      default: ;
    endcase
    o = '0; m = '0; hm = 0;
    if (!ld && !st) begin
      o.data = exu;
      o.fast = 1'b1;
    end else if ((a % size) != 0) begin
      o.err  = 1'b1;
      o.fast = 1'b1;
    end else begin
      hm      = 1;
      m.addr  = a - off;
      m.we    = st;
      m.wdata = d << (8 * off);
      m.wmask = st ? 4'(((1 << size) - 1) << off) : 4'd0;
      if (ld) begin
        mask = (64'd1 << (8 * size)) - 64'd1;
        w = ({32'd0, rd} >> (8 * off)) & mask;
        if (sgn && w[8*size-1]) w = w - (64'd1 << (8 * size));
        o.data = w[31:0];
      end
    end
  endfunction

  task automatic randomize_inputs();
    lsu_opt_code = 4'($urandom);
    addr         = $urandom;
    data_store   = $urandom;
    exu_res      = $urandom;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exu, input logic [31:0] rd);
    out_t o;
    mem_t m;
    bit   hm;
    int   guard;
    guard = 0;
    while (!in_ready) begin
      in_valid = noise ? 1'($urandom) : 1'b0;
      randomize_inputs();
      @(posedge clk); #1;
      guard++;
      if (guard > 300) begin
        check("issue_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    model(op, a, d, exu, rd, o, hm, m);
    out_q.push_back(o);
    if (hm) begin
      mem_q.push_back(m);
      rdata_q.push_back(rd);
    end
    in_valid = 1'b1; lsu_opt_code = op; addr = a; data_store = d; exu_res = exu;
    @(posedge clk); #1;
    in_valid = 1'b0;
    randomize_inputs();
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (out_q.size() != 0 || !in_ready) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 500) begin
        check("drain_timeout", out_q.size(), 32'd0);
        return;
      end
    end
  endtask

  // Monitor: checks in_ready, latency of non-memory results, memory requests and responses.
  bit   busy = 0;
  bit   fast_pending = 0;
  bit   hold_valid = 0;
  logic [31:0] hold_data;
  logic        hold_err;
  out_t mon_o;
  mem_t mon_m;

  always @(negedge clk) begin
    if (!rstn) begin
      busy = 0; fast_pending = 0; hold_valid = 0;
    end else begin
      check("in_ready", {31'd0, in_ready}, {31'd0, !busy});
      if (fast_pending) begin
        check("fast_latency_valid", {31'd0, out_valid}, 32'd1);
        check("fast_no_mem_req", {31'd0, mem_req}, 32'd0);
        fast_pending = 0;
      end
      if (hold_valid) begin
        check("resp_hold_valid", {31'd0, out_valid}, 32'd1);
        check("resp_hold_data", out_data, hold_data);
        check("resp_hold_err", {31'd0, out_err}, {31'd0, hold_err});
      end
      hold_valid = out_valid && !out_ready;
      hold_data  = out_data;
      hold_err   = out_err;
      if (mem_req) begin
        if (mem_q.size() == 0) begin
          check("unexpected_mem_req", {31'd0, mem_req}, 32'd0);
        end else begin
          mon_m = mem_q[0];
          check("mem_addr", mem_addr, mon_m.addr);
          check("mem_we", {31'd0, mem_we}, {31'd0, mon_m.we});
          if (mon_m.we) check("mem_wdata", mem_wdata, mon_m.wdata);
          check("mem_wmask", {28'd0, mem_wmask}, {28'd0, mon_m.wmask});
          if (mem_gnt) void'(mem_q.pop_front());
        end
      end
      if (out_valid && out_ready) begin
        if (out_q.size() == 0) begin
          check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          mon_o = out_q.pop_front();
          check("out_data", out_data, mon_o.data);
          check("out_err", {31'd0, out_err}, {31'd0, mon_o.err});
        end
        busy = 0;
      end
      if (in_valid && in_ready) begin
        busy = 1;
        fast_pending = (out_q.size() > 0) ? out_q[out_q.size()-1].fast : 1'b0;
      end
    end
  end

  // Memory responder: grant after gnt_cfg cycles, respond rv_cfg cycles after grant.
  int phase = 0;
  int gcnt  = 0;
  int rcnt  = 0;

  task automatic drive_rv();
    mem_rvalid = 1'b1;
    mem_rdata  = (rdata_q.size() > 0) ? rdata_q.pop_front() : $urandom;
  endtask

  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (manual_mem) begin
        phase = 0;
      end else begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
        if (!rstn) begin
          phase = 0;
        end else begin
          if (phase == 0) begin
            if (mem_req) begin
              gcnt  = (gnt_cfg >= 0) ? gnt_cfg : int'($urandom_range(0, 3));
              phase = 1;
            end else begin
              mem_rvalid = noise && ($urandom_range(0, 3) == 0);
            end
          end
          if (phase == 1) begin
            if (gcnt == 0) begin
              mem_gnt = 1'b1;
              rcnt = (rv_cfg >= 0) ? rv_cfg : int'($urandom_range(0, 3));
              if (rcnt == 0) begin drive_rv(); phase = 0; end
              else phase = 2;
            end else begin
              gcnt--;
              mem_rvalid = noise && ($urandom_range(0, 3) == 0);
            end
          end else if (phase == 2) begin
            rcnt--;
            if (rcnt == 0) begin drive_rv(); phase = 0; end
          end
        end
      end
    end
  end

  // WBU backpressure
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  logic [3:0] ops [16];
  int guard;

  initial begin
    for (int i = 0; i < 16; i++) ops[i] = 4'(i);
    rstn = 1'b0; in_valid = 1'b0;
    lsu_opt_code = '0; addr = '0; data_store = '0; exu_res = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wmask", {28'd0, mem_wmask}, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    gnt_cfg = 0; rv_cfg = 1;
    issue(4'd11, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, $urandom);
    wait_idle();
    gnt_cfg = 1; rv_cfg = 0;
    issue(4'd9, 32'h8000_0003, 32'h0000_00A5, 32'h0, $urandom);
    wait_idle();
    issue(4'd1, 32'h8000_0002, 32'h0, 32'h0, 32'h12F4_5678);
    issue(4'd4, 32'h8000_0002, 32'h0, 32'h0, 32'h12F4_5678);
    issue(4'd2, 32'h8000_0002, 32'h0, 32'h0, 32'h12F4_5678);
    issue(4'd3, 32'h8000_0002, 32'h0, 32'h0, $urandom);
    wait_idle();

    gnt_cfg = 3; rv_cfg = 2; stall_left = 4;
    issue(4'd3, 32'h8000_0008, 32'h0, 32'h0, 32'hCAFE_F00D);
    issue(4'd0, 32'h0000_1234, 32'h0, 32'h0000_1234, $urandom);
    wait_idle();

    // Reset while waiting for the memory response; the late response must be ignored.
    manual_mem = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    issue(4'd3, 32'h8000_0010, 32'h0, 32'h0, $urandom);
    guard = 0;
    while (!mem_req && guard < 20) begin @(posedge clk); #1; guard++; end
    check("rst_test_req_seen", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_data", out_data, 32'd0);
    check("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_mem_addr", mem_addr, 32'd0);
    check("mid_rst_mem_wmask", {28'd0, mem_wmask}, 32'd0);
    out_q.delete(); mem_q.delete(); rdata_q.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    repeat (3) begin
      check("post_rst_no_out_valid", {31'd0, out_valid}, 32'd0);
      check("post_rst_idle", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    manual_mem = 1'b0;

    gnt_cfg = -1; rv_cfg = -1; noise = 1'b1; rand_ready = 1'b1;
    repeat (300) begin
      issue(ops[$urandom_range(0, 15)], $urandom, $urandom, $urandom, $urandom);
    end
    wait_idle();
    check("final_queue_empty", out_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
